// File: rtl/ysyx_220066_wb_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// requester IDs, default starvation limit and the pending-slot record.
package ysyx_220066_wb_pkg;

    localparam logic [1:0] REQ_PIPE = 2'd0;
    localparam logic [1:0] REQ_MUL  = 2'd1;
    localparam logic [1:0] REQ_DIV  = 2'd2;
    localparam logic [1:0] REQ_NONE = 2'd3;

    localparam int STARVE_MAX_DEF = 4;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [63:0] data;
    } pend_t;

endpackage

// File: rtl/ysyx_220066_wb_slot.sv
// One-entry completion buffer for a multi-cycle unit; accepts a new result
// in the same cycle its current one is granted the write port.
module ysyx_220066_wb_slot
    import ysyx_220066_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [4:0]  i_rd,
    input  logic [63:0] i_data,
    input  logic        i_grant,
    output logic        o_ready,
    output logic        o_pend_valid,
    output logic [4:0]  o_pend_rd,
    output logic [63:0] o_pend_data
);

    pend_t r_pend;
    logic  w_accept;

    assign o_ready      = !r_pend.valid || i_grant;
    assign w_accept     = i_valid && o_ready;
    assign o_pend_valid = r_pend.valid;
    assign o_pend_rd    = r_pend.rd;
    assign o_pend_data  = r_pend.data;

    // A load on the grant edge overrides the drain, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend.valid <= 1'b1;
            r_pend.rd    <= i_rd;
            r_pend.data  <= i_data;
        end else if (i_grant) begin
            r_pend.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_220066_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. pending mul/div
// results, with round-robin between units and a starvation-forced stall.
module ysyx_220066_wb_arbiter
    import ysyx_220066_wb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_rd,
    input  logic [63:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mul_valid,
    input  logic [4:0]  mul_rd,
    input  logic [63:0] mul_data,
    output logic        mul_ready,
    input  logic        div_valid,
    input  logic [4:0]  div_rd,
    input  logic [63:0] div_data,
    output logic        div_ready,
    output logic        mul_pend_valid,
    output logic [4:0]  mul_pend_rd,
    output logic [63:0] mul_pend_data,
    output logic        div_pend_valid,
    output logic [4:0]  div_pend_rd,
    output logic [63:0] div_pend_data,
    output logic        rf_wen,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_data
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic          r_rr_ptr;
    logic [CW-1:0] r_starve_cnt;

    logic        w_any;
    logic        w_force;
    logic        w_rr_div;
    logic [1:0]  w_src;
    logic        w_stall;
    logic        w_mul_grant;
    logic        w_div_grant;
    logic        w_slot_grant;
    logic [4:0]  w_rd;
    logic [63:0] w_data;

    ysyx_220066_wb_slot u_mul_slot (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (mul_valid),
        .i_rd         (mul_rd),
        .i_data       (mul_data),
        .i_grant      (w_mul_grant),
        .o_ready      (mul_ready),
        .o_pend_valid (mul_pend_valid),
        .o_pend_rd    (mul_pend_rd),
        .o_pend_data  (mul_pend_data)
    );

    ysyx_220066_wb_slot u_div_slot (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (div_valid),
        .i_rd         (div_rd),
        .i_data       (div_data),
        .i_grant      (w_div_grant),
        .o_ready      (div_ready),
        .o_pend_valid (div_pend_valid),
        .o_pend_rd    (div_pend_rd),
        .o_pend_data  (div_pend_data)
    );

    assign w_any    = mul_pend_valid || div_pend_valid;
    assign w_force  = w_any && (r_starve_cnt == CNT_MAX);
    // A lone valid slot wins regardless of the pointer.
    assign w_rr_div = div_pend_valid && (!mul_pend_valid || r_rr_ptr);

    always_comb begin
        w_src   = REQ_NONE;
        w_stall = 1'b0;
        if (w_force) begin
            w_src   = w_rr_div ? REQ_DIV : REQ_MUL;
            w_stall = 1'b1;
        end else if (pipe_wen) begin
            w_src = REQ_PIPE;
        end else if (w_any) begin
            w_src = w_rr_div ? REQ_DIV : REQ_MUL;
        end
    end

    assign w_mul_grant  = (w_src == REQ_MUL);
    assign w_div_grant  = (w_src == REQ_DIV);
    assign w_slot_grant = w_mul_grant || w_div_grant;

    always_comb begin
        w_rd   = '0;
        w_data = '0;
        case (w_src)
            REQ_PIPE: begin w_rd = pipe_rd;     w_data = pipe_data;     end
            REQ_MUL:  begin w_rd = mul_pend_rd; w_data = mul_pend_data; end
            REQ_DIV:  begin w_rd = div_pend_rd; w_data = div_pend_data; end
            default:  ;
        endcase
    end

    // rd=0 still consumes the grant; reset blocks a pipeline write-through.
    assign rf_wen     = !rst && (w_src != REQ_NONE) && (w_rd != 5'd0);
    assign rf_rd      = w_rd;
    assign rf_data    = w_data;
    assign pipe_stall = w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_rr_ptr     <= 1'b0;
        end else begin
            if (w_slot_grant)
                r_starve_cnt <= '0;
            else if (w_any && r_starve_cnt != CNT_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;

            if (w_mul_grant)
                r_rr_ptr <= 1'b1;
            else if (w_div_grant)
                r_rr_ptr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_220066_wb_arbiter.sv
// Bench for the write-port arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_ysyx_220066_wb_arbiter;
    import ysyx_220066_wb_pkg::*;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wen = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [63:0] pipe_data = '0;
    logic        mul_valid = 1'b0;
    logic [4:0]  mul_rd = '0;
    logic [63:0] mul_data = '0;
    logic        div_valid = 1'b0;
    logic [4:0]  div_rd = '0;
    logic [63:0] div_data = '0;
    logic        pipe_stall, mul_ready, div_ready, rf_wen;
    logic        mul_pend_valid, div_pend_valid;
    logic [4:0]  mul_pend_rd, div_pend_rd, rf_rd;
    logic [63:0] mul_pend_data, div_pend_data, rf_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_220066_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data), .mul_ready(mul_ready),
        .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data), .div_ready(div_ready),
        .mul_pend_valid(mul_pend_valid), .mul_pend_rd(mul_pend_rd), .mul_pend_data(mul_pend_data),
        .div_pend_valid(div_pend_valid), .div_pend_rd(div_pend_rd), .div_pend_data(div_pend_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each slot is a (valid, rd, data) record; the owner of the port
    // each cycle is picked from the arbitration rules as a source number
    // (-1 none, 0 pipe, 1 mul, 2 div).
    bit          m_mv, m_dv, m_rr;
    logic [4:0]  m_mrd, m_drd;
    logic [63:0] m_mdat, m_ddat;
    int          m_cnt;
    int          e_src;
    bit          e_stall, e_wen, e_mrdy, e_drdy, any_v, pick_div;
    logic [4:0]  e_rd;
    logic [63:0] e_data;

    always @(negedge clk) begin
        if (rst) begin
            e_src = -1;
            chk("rst_rf_wen", rf_wen, 0);
            chk("rst_stall", pipe_stall, 0);
            chk("rst_mul_ready", mul_ready, 1);
            chk("rst_div_ready", div_ready, 1);
            chk("rst_mul_pv", mul_pend_valid, 0);
            chk("rst_div_pv", div_pend_valid, 0);
        end else begin
            any_v    = m_mv || m_dv;
            pick_div = m_dv && (!m_mv || m_rr);
            e_stall  = any_v && (m_cnt >= SM);
            if (e_stall)       e_src = pick_div ? 2 : 1;
            else if (pipe_wen) e_src = 0;
            else if (any_v)    e_src = pick_div ? 2 : 1;
            else               e_src = -1;
            e_rd   = (e_src == 0) ? pipe_rd   : (e_src == 1) ? m_mrd  : (e_src == 2) ? m_drd  : 5'd0;
            e_data = (e_src == 0) ? pipe_data : (e_src == 1) ? m_mdat : (e_src == 2) ? m_ddat : 64'd0;
            e_wen  = (e_src >= 0) && (e_rd != 0);
            e_mrdy = !m_mv || (e_src == 1);
            e_drdy = !m_dv || (e_src == 2);
            chk("rf_wen", rf_wen, e_wen);
            if (e_wen) begin
                chk("rf_rd", rf_rd, e_rd);
                chk("rf_data", rf_data, e_data);
            end
            chk("pipe_stall", pipe_stall, e_stall);
            chk("mul_ready", mul_ready, e_mrdy);
            chk("div_ready", div_ready, e_drdy);
            chk("mul_pend_valid", mul_pend_valid, m_mv);
            chk("div_pend_valid", div_pend_valid, m_dv);
            if (m_mv) begin
                chk("mul_pend_rd", mul_pend_rd, m_mrd);
                chk("mul_pend_data", mul_pend_data, m_mdat);
            end
            if (m_dv) begin
                chk("div_pend_rd", div_pend_rd, m_drd);
                chk("div_pend_data", div_pend_data, m_ddat);
            end
            if (e_src == 0 && pipe_rd != 0)
                chk("waw_order", (m_mv && m_mrd == pipe_rd) || (m_dv && m_drd == pipe_rd), 0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mv <= 0; m_dv <= 0; m_rr <= 0; m_cnt <= 0;
            m_mrd <= '0; m_drd <= '0; m_mdat <= '0; m_ddat <= '0;
        end else begin
            if (mul_valid && e_mrdy) begin
                m_mv <= 1; m_mrd <= mul_rd; m_mdat <= mul_data;
            end else if (e_src == 1) m_mv <= 0;
            if (div_valid && e_drdy) begin
                m_dv <= 1; m_drd <= div_rd; m_ddat <= div_data;
            end else if (e_src == 2) m_dv <= 0;
            if (e_src == 1 || e_src == 2) m_cnt <= 0;
            else if (m_mv || m_dv)        m_cnt <= (m_cnt >= SM) ? SM : m_cnt + 1;
            if (e_src == 1)      m_rr <= 1;
            else if (e_src == 2) m_rr <= 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick(input logic [31:0] avoid);
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        for (int t = 0; t < 64 && r != 0 && avoid[r]; t++) r = 5'($urandom_range(0, 31));
        if (r != 0 && avoid[r]) r = 5'd0;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          k;
    bit          stl, macc, dacc, acc;
    int          dens;
    logic [31:0] av;

    initial begin
        rst = 1;
        nxt(); nxt();
        rst = 0;
        smp();
        chk("idle_wen", rf_wen, 0);
        chk("idle_mul_ready", mul_ready, 1);

        // simultaneous mul/div offers, pipeline idle
        nxt();
        mul_valid = 1; mul_rd = 3; mul_data = 64'h33;
        div_valid = 1; div_rd = 4; div_data = 64'h44;
        smp();
        chk("t3_mul_ready", mul_ready, 1);
        chk("t3_div_ready", div_ready, 1);
        nxt(); mul_valid = 0; div_valid = 0;
        smp();
        chk("t3_first_wen", rf_wen, 1);
        chk("t3_first_rd", rf_rd, 3);
        nxt(); smp();
        chk("t3_second_rd", rf_rd, 4);
        chk("t3_second_data", rf_data, 64'h44);
        nxt(); smp();
        chk("t3_rr_ptr", dut.r_rr_ptr, 0);
        chk("t3_idle", rf_wen, 0);

        // single mul completion, port idle
        nxt(); mul_valid = 1; mul_rd = 5; mul_data = 64'h1234;
        smp();
        chk("t1_ready", mul_ready, 1);
        chk("t1_no_write", rf_wen, 0);
        nxt(); mul_valid = 0;
        smp();
        chk("t1_wen", rf_wen, 1);
        chk("t1_rd", rf_rd, 5);
        chk("t1_data", rf_data, 64'h1234);
        nxt(); smp();
        chk("t1_empty", mul_pend_valid, 0);

        // pipeline holds the port until starvation forces one stall
        nxt();
        mul_valid = 1; mul_rd = 7; mul_data = 64'h77;
        pipe_wen = 1; pipe_rd = 9; pipe_data = 64'h900;
        nxt(); mul_valid = 0;
        k = 0; stl = 0;
        for (int i = 0; i < 10; i++) begin
            if (!stl) begin
                pipe_rd = 5'(10 + k); pipe_data = 64'(256 + k); k++;
            end
            smp();
            if (i < 4) begin
                chk("t2_pipe_stall", pipe_stall, 0);
                chk("t2_pipe_rd", rf_rd, 10 + i);
            end
            if (i == 4) begin
                chk("t2_forced_stall", pipe_stall, 1);
                chk("t2_forced_wen", rf_wen, 1);
                chk("t2_forced_rd", rf_rd, 7);
            end
            if (i == 5) begin
                chk("t2_held_stall", pipe_stall, 0);
                chk("t2_held_rd", rf_rd, 14);
                chk("t2_held_data", rf_data, 64'(260));
            end
            stl = pipe_stall;
            nxt();
        end
        pipe_wen = 0;

        // rd=0 result drains without a write
        mul_valid = 1; mul_rd = 0; mul_data = 64'hdead;
        smp();
        nxt(); mul_valid = 0;
        smp();
        chk("t4_pv", mul_pend_valid, 1);
        chk("t4_no_wen", rf_wen, 0);
        chk("t4_ready", mul_ready, 1);
        nxt(); smp();
        chk("t4_drained", mul_pend_valid, 0);

        // full slot denied: no accept until the forced grant, refill with no gap
        nxt();
        pipe_wen = 1; pipe_rd = 20; pipe_data = 64'h20;
        mul_valid = 1; mul_rd = 8; mul_data = 64'h88;
        smp();
        nxt(); mul_rd = 9; mul_data = 64'h99;
        stl = 0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (!stl) begin pipe_rd = 5'(21 + i); pipe_data = 64'(21 + i); end
            if (acc) mul_valid = 0;
            smp();
            if (i < 4) chk("t5_denied", mul_ready, 0);
            if (i == 4) begin
                chk("t5_grant_ready", mul_ready, 1);
                chk("t5_grant_rd", rf_rd, 8);
            end
            if (i == 5) begin
                chk("t5_refill_pv", mul_pend_valid, 1);
                chk("t5_refill_rd", mul_pend_rd, 9);
                chk("t5_pipe_rd", rf_rd, 25);
            end
            acc = mul_valid && mul_ready;
            stl = pipe_stall;
            nxt();
        end
        pipe_wen = 0; mul_valid = 0;
        smp();
        chk("t5_drain_rd", rf_rd, 9);
        chk("t5_drain_data", rf_data, 64'h99);

        // asynchronous reset with both slots pending
        nxt();
        pipe_wen = 1; pipe_rd = 30; pipe_data = 64'h30;
        mul_valid = 1; mul_rd = 11; mul_data = 64'hb;
        div_valid = 1; div_rd = 12; div_data = 64'hc;
        nxt(); mul_valid = 0; div_valid = 0;
        smp();
        chk("t6_mul_pending", mul_pend_valid, 1);
        chk("t6_div_pending", div_pend_valid, 1);
        #1 rst = 1;
        #1;
        chk("t6_mul_dropped", mul_pend_valid, 0);
        chk("t6_div_dropped", div_pend_valid, 0);
        chk("t6_no_wen", rf_wen, 0);
        nxt(); rst = 0; pipe_wen = 0;
        mul_valid = 1; mul_rd = 5; mul_data = 64'h1234;
        smp();
        chk("t6_ready", mul_ready, 1);
        nxt(); mul_valid = 0;
        smp();
        chk("t6_rd", rf_rd, 5);
        chk("t6_wen", rf_wen, 1);

        // randomized traffic
        nxt();
        stl = 0; macc = 1; dacc = 1;
        for (int c = 0; c < 3000; c++) begin
            dens = (c < 1500) ? 2 : 8;
            if (!stl) begin
                av = '0;
                if (m_mv) av[m_mrd] = 1'b1;
                if (m_dv) av[m_drd] = 1'b1;
                if (mul_valid && !macc) av[mul_rd] = 1'b1;
                if (div_valid && !dacc) av[div_rd] = 1'b1;
                pipe_wen  = ($urandom % dens) != 0;
                pipe_rd   = pick(av);
                pipe_data = {$urandom, $urandom};
            end
            av = '0;
            if (pipe_wen) av[pipe_rd] = 1'b1;
            if (!mul_valid || macc) begin
                mul_valid = ($urandom % 3) == 0;
                mul_rd    = pick(av);
                mul_data  = {$urandom, $urandom};
            end
            if (!div_valid || dacc) begin
                div_valid = ($urandom % 4) == 0;
                div_rd    = pick(av);
                div_data  = {$urandom, $urandom};
            end
            smp();
            macc = mul_valid && mul_ready;
            dacc = div_valid && div_ready;
            stl  = pipe_stall;
            nxt();
        end
        pipe_wen = 0; mul_valid = 0; div_valid = 0;
        repeat (4) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_wb_arbiter.md
# ysyx_220066_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback and the two multi-cycle units (multiplier, divider). Each unit completion is held in a one-entry pending slot until it wins the port. The slot contents are exported so the register-read logic can bypass finished-but-unwritten results. The block sits between the WB stage, the mul/div units and the register file.

## Interface
- `STARVE_MAX`, default 4: consecutive cycles a pending unit result may be denied before the pipeline is stalled.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `pipe_wen` in 1: pipeline writeback request this cycle.
- `pipe_rd` in 5: pipeline destination register.
- `pipe_data` in 64: pipeline result.
- `pipe_stall` out 1: pipeline write deferred this cycle; WB must hold `pipe_wen`/`pipe_rd`/`pipe_data` unchanged.
- `mul_valid` in 1, `mul_rd` in 5, `mul_data` in 64: multiplier completion offer.
- `mul_ready` out 1: multiplier offer accepted this cycle when `mul_valid && mul_ready`.
- `div_valid`, `div_rd`, `div_data`, `div_ready`: same as the multiplier ports, for the divider.
- `mul_pend_valid` out 1, `mul_pend_rd` out 5, `mul_pend_data` out 64: multiplier slot contents, for bypass.
- `div_pend_valid`, `div_pend_rd`, `div_pend_data`: same as the multiplier slot outputs, for the divider slot.
- `rf_wen` out 1, `rf_rd` out 5, `rf_data` out 64: register-file write port.

## Operation
- Per-unit slot: `pend_valid`, `pend_rd`, `pend_data`.
  - `x_ready = !x_pend_valid || x_granted`, so a slot accepts a new result in the same cycle its old one drains.
  - On accept, the slot loads on the next edge.
- Grant order each cycle, evaluated combinationally from registered state:
  1. Forced mode (`starve_cnt == STARVE_MAX` and any slot valid): grant the slot selected by round-robin; `pipe_stall = 1`.
  2. Otherwise, if `pipe_wen`: grant the pipeline; `pipe_stall = 0`.
  3. Otherwise, grant one valid slot by round-robin.
- Round-robin: `rr_ptr` (1 bit, 0 = mul preferred).
  - If only one slot is valid, that slot wins.
  - After any slot grant, `rr_ptr` points to the other unit.
- Starvation counter `starve_cnt` (width clog2(STARVE_MAX+1)):
  - Increments, saturating, on any cycle with a valid slot and no slot grant.
  - Clears on any slot grant.
  - Holds when no slot is valid.
- Port drive: `rf_rd`/`rf_data` come from the granted source. `rf_wen = granted && rf_rd != 0`.
  - An rd=0 result still drains its slot, or consumes the pipeline request, without writing.
- Slots never pass each other and never drop data.
- WAW ordering between the pipeline and a pending slot is guaranteed by issue logic. The arbiter does not check it; the bench asserts it.

## Timing
- Reset values: all slots invalid, `pend_rd = 0`, `pend_data = 0`, `starve_cnt = 0`, `rr_ptr = 0`.
  - Outputs under reset: `rf_wen = 0`, `pipe_stall = 0`, `mul_ready = div_ready = 1`, all `*_pend_valid = 0`.
- Pipeline write latency: 0 cycles; the write is combinational through to the port when not stalled.
- Unit write latency: at least 1 cycle after accept; exactly 1 when the port is idle and the unit is preferred or alone.
- `pipe_stall` lasts exactly one cycle per forced grant.
  - The counter then clears, so back-to-back forced cycles need STARVE_MAX further denials.
  - Exception: the second slot may take the following cycle if `pipe_wen` is low.
- Simultaneous mul and div offers into empty slots: both are accepted in the same cycle.
- Reset asserted mid-operation: pending results are discarded immediately (asynchronous); the register file is not written.

## Structure
- Shared package `ysyx_220066_wb_pkg` holds:
  - requester IDs `REQ_PIPE = 0`, `REQ_MUL = 1`, `REQ_DIV = 2`;
  - the default `STARVE_MAX`;
  - the pend-slot struct (valid, rd[4:0], data[63:0]).
- Sub-module `ysyx_220066_wb_slot` (one-entry buffer with ready logic), instantiated twice.
- Grant mux, round-robin and starvation counter live in the top module.

## Test plan
- Idle port; `mul_valid` with rd=5, data=0x1234 → `mul_ready = 1`; next cycle `rf_wen = 1`, `rf_rd = 5`, `rf_data = 0x1234`; slot empty after.
- `pipe_wen` held high for 10 cycles with the mul slot pending (rd=7) and STARVE_MAX=4 → pipeline writes in cycles 0–3; cycle 4 `pipe_stall = 1` and rd=7 is written; cycle 5 the held pipeline data is written.
- mul and div offered in the same cycle (rd=3, rd=4), `pipe_wen` low → both accepted; rd=3 written the next cycle, then rd=4; `rr_ptr` ends at 0.
- Multiplier slot pending with rd=0, port free → slot drains, `rf_wen = 0`, `mul_ready = 1` in the same cycle.
- Slot full and denied, new `mul_valid` → `mul_ready = 0` until the grant cycle; the slot refills on that edge with no gap.
- Assert `rst` while both slots are pending → `*_pend_valid` drop immediately, no `rf_wen`; after release, the first offer behaves as from reset.
